// File: rtl/aes_iter_ctrl_if.sv
// aes_iter_ctrl_if
//   Key-load, plaintext and ciphertext handshakes of the iterative AES-128
//   sequencer, bundled so the bus adapter and the controller share one port.
//   master : upstream/downstream side (drives key, plaintext and out_ready)
//   slave  : aes_iter_ctrl side (drives key_ready, in_ready and ciphertext)
interface aes_iter_ctrl_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output key_load, key_in, in_valid, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  key_load, key_in, in_valid, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_iter_ctrl.sv
// aes_iter_ctrl
//   Sequencer for an iterative AES-128 encryptor. Holds the cipher key, does
//   the initial AddRoundKey on accept, then steps one external combinational
//   round unit and one key-generation unit through 10 rounds, one per cycle.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   bus             key / plaintext / ciphertext handshakes (slave modport)
//   busy            high while a block is in ROUND or DONE
//   rnd_state_in    state register fed to the round unit
//   rnd_key         round key fed to the round unit (= kg_key_out)
//   rnd_last        final round (no MixColumns) when the round counter is 9
//   rnd_state_out   round unit result
//   kg_round        round index 0..9 for Rcon selection
//   kg_key_in       previous round key (running key register)
//   kg_key_out      next round key from the key-generation unit
//   blk_cnt         completed-block count
//
// Build option
//   AES_ITER_CTRL_BLKCNT_EN : when defined, blk_cnt counts output handshakes
//   (wrapping); otherwise blk_cnt is tied to zero and no counter exists.
//
// state  | meaning
// IDLE   | waiting for key_load / plaintext
// ROUND  | one AES round per cycle, rc = 0..9
// DONE   | ciphertext held on out_data until out_ready
module aes_iter_ctrl #(
  parameter int NR    = 10,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  aes_iter_ctrl_if.slave     bus,
  output logic               busy,
  output logic [127:0]       rnd_state_in,
  output logic [127:0]       rnd_key,
  output logic               rnd_last,
  input  logic [127:0]       rnd_state_out,
  output logic [3:0]         kg_round,
  output logic [127:0]       kg_key_in,
  input  logic [127:0]       kg_key_out,
  output logic [CNT_W-1:0]   blk_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  localparam logic [3:0] RC_LAST = 4'(NR - 1);

  state_t       state, state_nxt;
  logic [127:0] mkey;
  logic [127:0] st;
  logic [127:0] rk;
  logic [3:0]   rc;
  logic         accept;
  logic         hshk;
  logic         last_rnd;

  assign accept   = bus.in_valid & bus.in_ready;
  assign hshk     = bus.out_valid & bus.out_ready;
  assign last_rnd = (rc == RC_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)   state_nxt = S_ROUND;
      S_ROUND: if (last_rnd) state_nxt = S_DONE;
      S_DONE:  if (hshk)     state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // key_load wins over in_valid in the same cycle so a block never starts
  // with a key that is being replaced on that very edge.
  always_comb begin
    bus.in_ready = (state == S_IDLE) & bus.key_ready & ~bus.key_load;
    busy         = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mkey          <= '0;
      st            <= '0;
      rk            <= '0;
      rc            <= '0;
      bus.key_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      // keys arriving mid-block are dropped, not queued
      if (state == S_IDLE && bus.key_load) begin
        mkey          <= bus.key_in;
        bus.key_ready <= 1'b1;
      end
      if (accept) begin
        st <= bus.in_data ^ mkey;
        rk <= mkey;
        rc <= '0;
      end
      if (state == S_ROUND) begin
        st <= rnd_state_out;
        rk <= kg_key_out;
        // rc parks at the last round index instead of wrapping
        if (last_rnd) begin
          bus.out_data  <= rnd_state_out;
          bus.out_valid <= 1'b1;
        end else begin
          rc <= rc + 4'd1;
        end
      end
      if (hshk) bus.out_valid <= 1'b0;
    end
  end

  assign rnd_state_in = st;
  assign rnd_key      = kg_key_out;
  assign rnd_last     = last_rnd;
  assign kg_round     = rc;
  assign kg_key_in    = rk;

`ifdef AES_ITER_CTRL_BLKCNT_EN
  logic [CNT_W-1:0] blk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)       blk_cnt_q <= '0;
    else if (hshk) blk_cnt_q <= blk_cnt_q + 1'b1;
  end

  assign blk_cnt = blk_cnt_q;
`else
  assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_aes_iter_ctrl.sv
module tb_aes_iter_ctrl;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic         busy;
  logic [127:0] rnd_state_in, rnd_key, rnd_state_out;
  logic         rnd_last;
  logic [3:0]   kg_round;
  logic [127:0] kg_key_in, kg_key_out;
  logic [31:0]  blk_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  aes_iter_ctrl_if bus ();

  aes_iter_ctrl #(.NR(10), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .busy          (busy),
    .rnd_state_in  (rnd_state_in),
    .rnd_key       (rnd_key),
    .rnd_last      (rnd_last),
    .rnd_state_out (rnd_state_out),
    .kg_round      (kg_round),
    .kg_key_in     (kg_key_in),
    .kg_key_out    (kg_key_out),
    .blk_cnt       (blk_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference AES round / key-schedule datapath ----------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] p = a;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    if (a == 8'h00) r = 8'h00;
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[c*4+r] = a[((c + r) % 4)*4 + r];
    for (int c = 0; c < 4; c++) begin
      m[c*4+0] = xt(b[c*4]) ^ xt(b[c*4+1]) ^ b[c*4+1] ^ b[c*4+2] ^ b[c*4+3];
      m[c*4+1] = b[c*4] ^ xt(b[c*4+1]) ^ xt(b[c*4+2]) ^ b[c*4+2] ^ b[c*4+3];
      m[c*4+2] = b[c*4] ^ b[c*4+1] ^ xt(b[c*4+2]) ^ xt(b[c*4+3]) ^ b[c*4+3];
      m[c*4+3] = xt(b[c*4]) ^ b[c*4] ^ b[c*4+1] ^ b[c*4+2] ^ xt(b[c*4+3]);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = last ? b[i] : m[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [3:0] rnd);
    logic [7:0]  rcon = 8'h01;
    logic [31:0] w3 = k[31:0];
    logic [31:0] t, n0, n1, n2, n3;
    for (int i = 0; i < 10; i++) if (i < int'(rnd)) rcon = xt(rcon);
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign kg_key_out    = key_exp(kg_key_in, kg_round);
  assign rnd_state_out = aes_round(rnd_state_in, rnd_key, rnd_last);

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    bus.key_load = 1'b1;
    bus.key_in   = k;
    @(negedge clk);
    bus.key_load = 1'b0;
  endtask

  // Issue one block (unless already driven at the current negedge), check
  // latency and ciphertext, optional backpressure and a mid-round key_load.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp_ct,
                           input int hold, input bit mid_kl, input logic [127:0] mid_key,
                           input bit pre_issued);
    int edges;
    bit got_ov;
    bit ok;
    if (!pre_issued) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = pt;
      #1 chk({tag, " in_ready"}, 128'(bus.in_ready), 128'd1);
    end
    bus.out_ready = (hold == 0);
    edges  = -1;
    got_ov = 1'b0;
    while (edges < 30 && !got_ov) begin
      @(negedge clk);
      edges++;
      bus.in_valid = 1'b0;
      bus.key_load = 1'b0;
      if (mid_kl && edges == 4) begin
        bus.key_load = 1'b1;
        bus.key_in   = mid_key;
      end
      #1 if (bus.out_valid) got_ov = 1'b1;
    end
    chk({tag, " latency"}, 128'(edges), 128'd10);
    chk({tag, " out_data"}, bus.out_data, exp_ct);
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        #1 ok = ok & bus.out_valid & (bus.out_data == exp_ct) & ~bus.in_ready & busy;
      end
      chk({tag, " hold stable"}, 128'(ok), 128'd1);
      @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    chk({tag, " ov clear"}, 128'(bus.out_valid), 128'd0);
    chk({tag, " in_ready back"}, 128'(bus.in_ready), 128'd1);
  endtask

  initial begin : stim
    bit ok;
    rst           = 1'b1;
    bus.key_load  = 1'b0;
    bus.key_in    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst key_ready", 128'(bus.key_ready), 128'd0);
    chk("rst out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst out_data", bus.out_data, 128'd0);
    chk("rst busy", 128'(busy), 128'd0);
    chk("rst blk_cnt", 128'(blk_cnt), 128'd0);

    // plaintext before any key: refused
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = P2;
    #1 chk("nokey in_ready", 128'(bus.in_ready), 128'd0);
    repeat (3) @(negedge clk);
    #1 chk("nokey busy", 128'(busy), 128'd0);
    bus.in_valid = 1'b0;

    load_key(K2);
    #1 chk("k2 key_ready", 128'(bus.key_ready), 128'd1);
    run_block("aes2", P2, C2, 0, 1'b0, '0, 1'b0);

    load_key(K1);
    run_block("fips", P1, C1, 0, 1'b0, '0, 1'b0);
    run_block("bp", P1, C1, 20, 1'b0, '0, 1'b0);

    // key_load during ROUND is ignored for this and later blocks
    run_block("klmid", P1, C1, 0, 1'b1, K2, 1'b0);
    run_block("klafter", P1, C1, 0, 1'b0, '0, 1'b0);
    load_key(K2);
    run_block("klnew", P2, C2, 0, 1'b0, '0, 1'b0);

    // key_load and in_valid together: key wins, data next cycle with new key
    @(negedge clk);
    bus.key_load = 1'b1;
    bus.key_in   = K1;
    bus.in_valid = 1'b1;
    bus.in_data  = P1;
    #1 chk("kl+iv in_ready", 128'(bus.in_ready), 128'd0);
    @(negedge clk);
    bus.key_load = 1'b0;
    #1;
    chk("kl+iv busy", 128'(busy), 128'd0);
    chk("kl+iv in_ready2", 128'(bus.in_ready), 128'd1);
    run_block("kl+iv", P1, C1, 0, 1'b0, '0, 1'b1);

    // reset at round 5 aborts the block
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = P1;
    repeat (6) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    #1 chk("mid rc", 128'(kg_round), 128'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst out_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst key_ready", 128'(bus.key_ready), 128'd0);
    chk("midrst busy", 128'(busy), 128'd0);
    chk("midrst blk_cnt", 128'(blk_cnt), 128'd0);
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      #1 ok = ok & ~bus.out_valid;
    end
    chk("midrst no output", 128'(ok), 128'd1);

    load_key(K2);
    for (int i = 0; i < 3; i++) run_block("b2b", P2, C2, 0, 1'b0, '0, 1'b0);
`ifdef AES_ITER_CTRL_BLKCNT_EN
    chk("blk_cnt 3", 128'(blk_cnt), 128'd3);
`else
    chk("blk_cnt off", 128'(blk_cnt), 128'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("blk_cnt rst", 128'(blk_cnt), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
